// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - MIPS load/store opcodes handled by the responder
//   - FSM state encoding
//   - access width encoding and an opcode classifier returning
//     width, signedness, store flag and legality
package dmem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Prefixed so the WAIT state name cannot collide with the WAIT parameter.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        WID_B,
        WID_H,
        WID_W
    } width_t;

    typedef struct packed {
        logic   legal;
        width_t width;
        logic   is_signed;
        logic   is_store;
    } op_class_t;

    function automatic op_class_t classify_op(input logic [5:0] op);
        op_class_t c;
        c.legal     = 1'b1;
        c.width     = WID_W;
        c.is_signed = 1'b0;
        c.is_store  = 1'b0;
        case (op)
            OP_LB:   begin c.width = WID_B; c.is_signed = 1'b1; end
            OP_LH:   begin c.width = WID_H; c.is_signed = 1'b1; end
            OP_LW:   c.width = WID_W;
            OP_LBU:  c.width = WID_B;
            OP_LHU:  c.width = WID_H;
            OP_SB:   begin c.width = WID_B; c.is_store = 1'b1; end
            OP_SH:   begin c.width = WID_H; c.is_store = 1'b1; end
            OP_SW:   begin c.width = WID_W; c.is_store = 1'b1; end
            default: c.legal = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational lane steering for the data-memory responder.
//   old_word    : word currently stored at the addressed location
//   wdata       : store data (low byte / low half used for SB / SH)
//   byte_sel    : addr[1:0], little-endian byte lane
//   width       : access width (byte / half / word)
//   is_signed   : sign-extend loads when set
//   merged_word : old_word with the addressed lane(s) replaced by store data
//   load_data   : addressed lane(s) extended to 32 bits
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  byte_sel,
    input  width_t      width,
    input  logic        is_signed,
    output logic [31:0] merged_word,
    output logic [31:0] load_data
);

    // Store path: each byte lane decides independently whether it is
    // overwritten and which byte of wdata it takes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic       be;
        logic [7:0] src;

        always_comb begin
            be  = 1'b1;
            src = wdata[8*gi +: 8];
            case (width)
                WID_B: begin
                    be  = (byte_sel == LANE);
                    src = wdata[7:0];
                end
                WID_H: begin
                    be  = (byte_sel[1] == LANE[1]);
                    src = wdata[8*(gi%2) +: 8];
                end
                default: begin
                    be  = 1'b1;
                    src = wdata[8*gi +: 8];
                end
            endcase
        end

        assign merged_word[8*gi +: 8] = be ? src : old_word[8*gi +: 8];
    end

    // Load path: bring the addressed lane down to bit 0, then extend.
    logic [31:0] shifted;
    assign shifted = old_word >> {byte_sel, 3'b000};

    always_comb begin
        load_data = old_word;
        case (width)
            WID_B:   load_data = {{24{is_signed & shifted[7]}},  shifted[7:0]};
            WID_H:   load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            default: load_data = old_word;
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// Multi-cycle, wait-stated data-memory responder for the CPU memory stage.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   req_valid  : request present
//   req_ready  : high only while idle
//   req_op     : MIPS load/store opcode
//   req_addr   : byte address
//   req_wdata  : store data
//   rsp_valid  : one-cycle completion pulse
//   rsp_rdata  : extended load result, 0 for stores and errors
//   rsp_err    : misaligned access or illegal opcode, valid with rsp_valid
// The word is read into a register on acceptance (only one request is ever
// outstanding, so it stays current); a store is written at the end of the
// wait period, and the response is registered on the way out of RESP.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         DEPTH    = 1 << (ADDR_W - 2);
    localparam logic [3:0] CNT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    logic [31:0] mem [DEPTH];

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [5:0]        op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       rd_word_reg;
    logic              rsp_valid_reg;
    logic [31:0]       rsp_rdata_reg;
    logic              rsp_err_reg;

    op_class_t   cls;
    logic        err;
    logic        accept;
    logic        exec;
    logic        do_write;
    logic [31:0] merged_word;
    logic [31:0] load_data;

    assign req_ready = (state_reg == S_IDLE);
    assign accept    = req_valid & req_ready;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

    assign cls = classify_op(op_reg);
    assign err = !cls.legal
               || (cls.width == WID_W && addr_reg[1:0] != 2'b00)
               || (cls.width == WID_H && addr_reg[0]);

    // The access executes on the last wait cycle; with no wait states the
    // only candidate edge is the one leaving RESP.
    assign exec     = (WAIT > 0) ? (state_reg == S_WAIT && cnt_reg == 4'd0)
                                 : (state_reg == S_RESP);
    assign do_write = exec & cls.is_store & ~err;

    dmem_lane u_lane (
        .old_word    (rd_word_reg),
        .wdata       (wdata_reg),
        .byte_sel    (addr_reg[1:0]),
        .width       (cls.width),
        .is_signed   (cls.is_signed),
        .merged_word (merged_word),
        .load_data   (load_data)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT > 0) begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        state_next = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= 4'd0;
            op_reg        <= 6'd0;
            addr_reg      <= '0;
            wdata_reg     <= 32'd0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            if (accept) begin
                op_reg    <= req_op;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
            end
            rsp_valid_reg <= (state_reg == S_RESP);
            rsp_err_reg   <= (state_reg == S_RESP) & err;
            rsp_rdata_reg <= (state_reg == S_RESP && !err && !cls.is_store)
                             ? load_data : 32'd0;
        end
    end

    // Storage: not reset. Writes are gated by state, which reset forces to
    // IDLE, so a pending store is dropped when reset arrives first.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_word_reg <= mem[req_addr[ADDR_W-1:2]];
        end
        if (do_write) begin
            mem[addr_reg[ADDR_W-1:2]] <= merged_word;
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

    typedef struct {
        logic [5:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    localparam int NV = 18;

    vec_t vecs [NV] = '{
        '{6'h2B, 12'h010, 32'h12345678, 32'h00000000, 1'b0},
        '{6'h23, 12'h010, 32'h00000000, 32'h12345678, 1'b0},
        '{6'h28, 12'h011, 32'h000000AB, 32'h00000000, 1'b0},
        '{6'h23, 12'h010, 32'h00000000, 32'h1234AB78, 1'b0},
        '{6'h20, 12'h011, 32'h00000000, 32'hFFFFFFAB, 1'b0},
        '{6'h24, 12'h011, 32'h00000000, 32'h000000AB, 1'b0},
        '{6'h29, 12'h012, 32'h00008001, 32'h00000000, 1'b0},
        '{6'h21, 12'h012, 32'h00000000, 32'hFFFF8001, 1'b0},
        '{6'h25, 12'h012, 32'h00000000, 32'h00008001, 1'b0},
        '{6'h23, 12'h010, 32'h00000000, 32'h8001AB78, 1'b0},
        '{6'h23, 12'h013, 32'h00000000, 32'h00000000, 1'b1},
        '{6'h29, 12'h011, 32'h00005555, 32'h00000000, 1'b1},
        '{6'h23, 12'h010, 32'h00000000, 32'h8001AB78, 1'b0},
        '{6'h3F, 12'h010, 32'h00000000, 32'h00000000, 1'b1},
        '{6'h21, 12'h010, 32'h00000000, 32'hFFFFAB78, 1'b0},
        '{6'h20, 12'h013, 32'h00000000, 32'hFFFFFF80, 1'b0},
        '{6'h2B, 12'h020, 32'h0BADF00D, 32'h00000000, 1'b0},
        '{6'h23, 12'h020, 32'h00000000, 32'h0BADF00D, 1'b0}
    };

    int wait_of [2] = '{2, 0};

    logic        clk;
    logic        rst   [2];
    logic        rv    [2];
    logic [5:0]  rop   [2];
    logic [11:0] raddr [2];
    logic [31:0] rwd   [2];
    logic        rready[2];
    logic        rrv   [2];
    logic [31:0] rrd   [2];
    logic        rerr  [2];

    int vectors = 0;
    int fails   = 0;

    dmem_resp #(.ADDR_W(12), .WAIT(2)) u_dut_w2 (
        .clk(clk), .rst(rst[0]),
        .req_valid(rv[0]), .req_ready(rready[0]), .req_op(rop[0]),
        .req_addr(raddr[0]), .req_wdata(rwd[0]),
        .rsp_valid(rrv[0]), .rsp_rdata(rrd[0]), .rsp_err(rerr[0])
    );

    dmem_resp #(.ADDR_W(12), .WAIT(0)) u_dut_w0 (
        .clk(clk), .rst(rst[1]),
        .req_valid(rv[1]), .req_ready(rready[1]), .req_op(rop[1]),
        .req_addr(raddr[1]), .req_wdata(rwd[1]),
        .rsp_valid(rrv[1]), .rsp_rdata(rrd[1]), .rsp_err(rerr[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mmem   [2][1024];
    bit          mknown [2][1024];
    bit          pend   [2];
    bit          due    [2];
    int          age    [2];
    logic [31:0] exp_rd [2];
    logic        exp_err[2];
    bit          exp_known[2];
    logic        pw     [2];
    logic [31:0] pnew   [2];
    int          pidx   [2];

    // Arithmetic description of one access: size in bytes, offset in
    // bytes, mask/shift in plain integer math.
    function automatic void model_access(input logic [5:0] op, input int unsigned addr,
                                         input logic [31:0] wd, input logic [31:0] word,
                                         output logic [31:0] rd, output logic er,
                                         output logic wr, output logic [31:0] nw);
        int     size;
        bit     sgn, st, legal;
        longint span, off, mask, v;
        legal = 1; sgn = 0; st = 0; size = 4;
        case (op)
            6'h20: begin size = 1; sgn = 1; end
            6'h21: begin size = 2; sgn = 1; end
            6'h23: size = 4;
            6'h24: size = 1;
            6'h25: size = 2;
            6'h28: begin size = 1; st = 1; end
            6'h29: begin size = 2; st = 1; end
            6'h2B: begin size = 4; st = 1; end
            default: legal = 0;
        endcase
        er = !legal || ((addr % size) != 0);
        rd = 32'd0;
        wr = 1'b0;
        nw = word;
        if (!er) begin
            span = longint'(1) << (8 * size);
            off  = longint'(addr % 4);
            if (st) begin
                mask = (span - 1) << (8 * off);
                nw = 32'((longint'(word) & ~mask) | ((longint'(wd) << (8 * off)) & mask));
                wr = 1'b1;
            end else begin
                v = (longint'(word) >> (8 * off)) % span;
                if (sgn && v >= span / 2) v = v - span;
                rd = 32'(v);
            end
        end
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            pend[d] = 0; due[d] = 0; age[d] = 0;
            for (int i = 0; i < 1024; i++) mknown[d][i] = 0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst[d]) begin
                    pend[d] = 0;
                    due[d]  = 0;
                end else begin
                    bit ready_before;
                    ready_before = !pend[d];
                    due[d] = 0;
                    if (pend[d]) begin
                        age[d]++;
                        if (age[d] == wait_of[d] + 1) begin
                            due[d]  = 1;
                            pend[d] = 0;
                            if (pw[d]) begin
                                mmem[d][pidx[d]]   = pnew[d];
                                mknown[d][pidx[d]] = 1;
                            end
                        end
                    end
                    if (ready_before && rv[d]) begin
                        logic [31:0] r, n;
                        logic        e, w;
                        pend[d] = 1;
                        age[d]  = 0;
                        pidx[d] = int'(raddr[d]) / 4;
                        model_access(rop[d], raddr[d], rwd[d], mmem[d][pidx[d]], r, e, w, n);
                        exp_rd[d]    = r;
                        exp_err[d]   = e;
                        pw[d]        = w;
                        pnew[d]      = n;
                        exp_known[d] = mknown[d][pidx[d]] || e || (rop[d] >= 6'h28);
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both responders against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("rsp_valid", d, 32'(rrv[d]), 32'(due[d]));
                if (rst[d]) chk("req_ready", d, 32'(rready[d]), 32'(!pend[d]));
                if (due[d]) begin
                    chk("rsp_err", d, 32'(rerr[d]), 32'(exp_err[d]));
                    if (exp_known[d]) chk("rsp_rdata", d, rrd[d], exp_rd[d]);
                end else begin
                    chk("idle_rdata", d, rrd[d], 32'd0);
                    chk("idle_err", d, 32'(rerr[d]), 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input int d, input vec_t v);
        int          t, e;
        bit          got;
        logic [31:0] g_rd;
        logic        g_err;
        @(negedge clk);
        rv[d] = 1'b1; rop[d] = v.op; raddr[d] = v.addr; rwd[d] = v.wdata;
        t = 0;
        while (!rready[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            chk("accept_timeout", d, 32'd0, 32'd1);
            rv[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 rv[d] = 1'b0;
        e = 0; got = 0; g_rd = 32'd0; g_err = 1'b0;
        while (e < 40 && !got) begin
            @(posedge clk);
            #1;
            e++;
            if (rrv[d]) begin
                got = 1; g_rd = rrd[d]; g_err = rerr[d];
            end
        end
        $display("dut%0d op=%h addr=%h wdata=%h -> rdata=%h err=%b latency=%0d",
                 d, v.op, v.addr, v.wdata, g_rd, g_err, e);
        chk("latency", d, 32'(e), 32'(wait_of[d] + 1));
        chk("lit_rdata", d, g_rd, v.rd);
        chk("lit_err", d, 32'(g_err), 32'(v.err));
    endtask

    task automatic hold_test(input int d);
        int n, pulses;
        @(negedge clk);
        rv[d] = 1'b1; rop[d] = 6'h3F; raddr[d] = 12'h010; rwd[d] = 32'd0;
        n = 2 * (wait_of[d] + 2);
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (rrv[d]) pulses++;
        end
        rv[d] = 1'b0;
        $display("dut%0d illegal op held %0d cycles -> %0d responses", d, n, pulses);
        chk("hold_pulses", d, 32'(pulses), 32'd2);
    endtask

    task automatic reset_test(input int d);
        vec_t lw;
        int   pulses;
        @(negedge clk);
        rv[d] = 1'b1; rop[d] = 6'h2B; raddr[d] = 12'h020; rwd[d] = 32'hDEADBEEF;
        @(posedge clk);
        #1 rv[d] = 1'b0;
        @(posedge clk);
        #1 rst[d] = 1'b0;
        #1;
        chk("rst_ready", d, 32'(rready[d]), 32'd1);
        chk("rst_valid", d, 32'(rrv[d]), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst[d] = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (rrv[d]) pulses++;
        end
        $display("dut%0d reset during wait of SW DEADBEEF -> %0d responses", d, pulses);
        chk("rst_no_rsp", d, 32'(pulses), 32'd0);
        chk("rst_ready_after", d, 32'(rready[d]), 32'd1);
        lw = '{6'h23, 12'h020, 32'h0, 32'h0BADF00D, 1'b0};
        do_req(d, lw);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; rv[d] = 1'b0; rop[d] = 6'd0; raddr[d] = 12'd0; rwd[d] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", d, 32'(rready[d]), 32'd1);
            chk("reset_valid", d, 32'(rrv[d]), 32'd0);
            chk("reset_rdata", d, rrd[d], 32'd0);
            chk("reset_err", d, 32'(rerr[d]), 32'd0);
        end
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NV; i++) do_req(d, vecs[i]);
            hold_test(d);
        end
        reset_test(0);
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
